axi_chan_buffer: RTL and testbench
==================================

Name: axi_chan_buffer

Overview:
- Parametrised successor to the single-register AXI cut: each of the five AXI channels gets an independently sized FIFO buffer, or a combinational bypass.
- Adds a transaction-aware isolate/drain handshake, so that a master port can be quiesced safely before reset or clock gating of the downstream slave.
- Sits between an AXI master and a crossbar or slave on timing-critical or power-domain boundaries.

Parameters:
- AwDepth, 2, AW FIFO depth; 0 = bypass; 1 is illegal (elaboration $fatal).
- WDepth, 2, W FIFO depth; same rules.
- BDepth, 2, B FIFO depth; same rules.
- ArDepth, 2, AR FIFO depth; same rules.
- RDepth, 2, R FIFO depth; same rules.
- MaxTxns, 8, maximum outstanding writes and maximum outstanding reads tracked (each ≥1).
- aw_chan_t / w_chan_t / b_chan_t / ar_chan_t / r_chan_t, logic, AXI channel structs; r_chan_t has a last field.
- axi_req_t / axi_resp_t, logic, AXI request/response structs.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- slv_req_i  in  axi_req_t  slave-port request
- slv_resp_o  out  axi_resp_t  slave-port response
- mst_req_o  out  axi_req_t  master-port request
- mst_resp_i  in  axi_resp_t  master-port response
- isolate_i  in  1  request isolation; blocks new AW/AR
- isolated_o  out  1  isolation complete
- stall_cnt_o  out  32  AW/AR stall cycle count (optional feature)

Behaviour:
- One clock; reset is asynchronous and active-low (rst_ni). All FIFOs empty, counters zero.
- Reset values: all valid/ready outputs 0, data outputs '0, isolated_o 0, stall_cnt_o 0.
- Per-channel FIFO with Depth ≥2:
  - ready_o = !full; valid_o = !empty; data_o is driven from storage only. No combinational path in either direction.
  - Latency: 1 cycle from input handshake to output valid.
  - Full throughput of 1 beat/cycle. Simultaneous push and pop when full is not allowed (ready_o=0). Simultaneous push and pop when non-empty keeps the count unchanged.
  - Pointers wrap modulo Depth; Depth need not be a power of two.
- Depth = 0: the channel is wired straight through (valid, ready and data combinational).
- Write counter wr_cnt, $clog2(MaxTxns+1) bits:
  - +1 on slave AW handshake; −1 on slave B handshake; simultaneous +1/−1 leaves it unchanged.
  - Read counter rd_cnt behaves identically: +1 on slave AR handshake, −1 on slave R handshake with r.last=1.
- Admission gating:
  - Slave aw_ready = fifo_aw_ready && !isolate_i && (wr_cnt < MaxTxns).
  - Slave ar_ready follows the same rule with rd_cnt.
  - The FIFO push is the gated handshake, so a rejected AW/AR keeps its valid held and stays compliant.
- W, B and R are never gated by isolate_i, so in-flight bursts complete.
- An AW/AR already in its FIFO still drains to the master port while isolated. Master-side valid is never retracted.
- isolated_o (registered) = isolate_i && wr_cnt==0 && rd_cnt==0 && all five FIFOs empty. It updates one cycle after the condition holds.
- Deasserting isolate_i clears isolated_o next cycle; admission resumes the same cycle isolate_i is low.
- Reset mid-transfer discards all buffered beats and counters.
- Counter underflow (B/R-last without a matching request) is a protocol error: simulation assertion, counter holds at 0.

Optional Feature:
- Macro AXI_CHAN_BUFFER_STALL_CNT_EN.
- Defined: stall_cnt_o is a 32-bit saturating counter. It increments each cycle where (slv aw_valid && !slv aw_ready) || (slv ar_valid && !slv ar_ready), and holds at 32'hFFFF_FFFF.
- Undefined: the counter logic is not built and stall_cnt_o is tied to 0.

Test Plan:
- All depths 2: stream 16 back-to-back W beats with master w_ready=1 -> master w_valid asserts 1 cycle after the first slave handshake; 16 beats in 17 cycles; no bubbles.
- WDepth=4, master w_ready=0: push 5 beats -> slave w_ready drops after 4th push; 5th beat held; release ready -> beats emerge in order.
- AwDepth=0, others 2: AW handshake -> mst aw_valid combinationally equals slv aw_valid in the same cycle.
- MaxTxns=2: issue 3 AWs with no B -> 3rd AW blocked (aw_ready=0); return 1 B -> 3rd accepted next handshake cycle.
- 1 write + 1 read outstanding, assert isolate_i -> new AR blocked, pending W/B/R complete; isolated_o=1 exactly one cycle after the last R(last) handshake; drop isolate_i -> isolated_o=0 next cycle.
- With AXI_CHAN_BUFFER_STALL_CNT_EN: hold slv aw_valid=1 with isolate_i=1 for 10 cycles -> stall_cnt_o=10. Without the macro -> stall_cnt_o=0.

Source files
------------

// File: rtl/axi_chan_buffer_if.sv
// axi_chan_buffer_if: one AXI port as a request/response struct pair.
// The master view drives the request; the slave view drives the response.
interface axi_chan_buffer_if #(
  parameter type req_t  = logic,
  parameter type resp_t = logic
);
  req_t  req;
  resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/axi_chan_buffer.sv
// axi_chan_buffer: per-channel FIFO (or bypass) AXI cut with an isolate/drain handshake.
// Define AXI_CHAN_BUFFER_STALL_CNT_EN to build the saturating AW/AR stall counter.
// Handshake rule on every channel: a beat moves on a rising edge where valid and ready
// are both high; valid never depends on ready and is held until accepted.

module axi_chan_buffer_fifo #(
  parameter int unsigned Depth = 2,
  parameter type data_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  valid_i,
  output logic  ready_o,
  input  data_t data_i,
  output logic  valid_o,
  input  logic  ready_i,
  output data_t data_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  data_t           mem_q [Depth];
  data_t           mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            live_q;
  logic            push, pop;

  // live_q keeps ready low while in reset so every handshake output starts at 0.
  assign ready_o = live_q && (cnt_q != CntW'(Depth));
  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      live_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      live_q   <= 1'b1;
    end
  end
endmodule

module axi_chan_buffer #(
  parameter int unsigned AwDepth = 2,
  parameter int unsigned WDepth  = 2,
  parameter int unsigned BDepth  = 2,
  parameter int unsigned ArDepth = 2,
  parameter int unsigned RDepth  = 2,
  parameter int unsigned MaxTxns = 8,
  parameter type aw_chan_t = struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; },
  parameter type w_chan_t  = struct packed { logic [31:0] data; logic last; },
  parameter type b_chan_t  = struct packed { logic [3:0] id; logic [1:0] resp; },
  parameter type ar_chan_t = struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; },
  parameter type r_chan_t  = struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; },
  parameter type axi_req_t = struct packed {
    aw_chan_t aw; logic aw_valid; w_chan_t w; logic w_valid; logic b_ready;
    ar_chan_t ar; logic ar_valid; logic r_ready; },
  parameter type axi_resp_t = struct packed {
    logic aw_ready; logic ar_ready; logic w_ready; b_chan_t b; logic b_valid;
    r_chan_t r; logic r_valid; }
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  axi_req_t    slv_req_i,
  output axi_resp_t   slv_resp_o,
  output axi_req_t    mst_req_o,
  input  axi_resp_t   mst_resp_i,
  input  logic        isolate_i,
  output logic        isolated_o,
  output logic [31:0] stall_cnt_o
);
  localparam int unsigned TxnW = $clog2(MaxTxns + 1);

  if (AwDepth == 1 || WDepth == 1 || BDepth == 1 || ArDepth == 1 || RDepth == 1) begin : g_bad_depth
    $fatal(1, "axi_chan_buffer: a channel depth of 1 is not supported");
  end
  if (MaxTxns < 1) begin : g_bad_txns
    $fatal(1, "axi_chan_buffer: MaxTxns must be at least 1");
  end

  aw_chan_t aw_out;
  w_chan_t  w_out;
  b_chan_t  b_out;
  ar_chan_t ar_out;
  r_chan_t  r_out;
  logic aw_in_valid, aw_in_ready, aw_out_valid, aw_empty, aw_adm, aw_slv_ready;
  logic ar_in_valid, ar_in_ready, ar_out_valid, ar_empty, ar_adm, ar_slv_ready;
  logic w_in_ready, w_out_valid, w_empty;
  logic b_in_ready, b_out_valid, b_empty;
  logic r_in_ready, r_out_valid, r_empty;
  logic aw_hs, b_hs, ar_hs, r_last_hs;
  logic [TxnW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic isolated_q, isolated_d;

  // Only the request channels are gated; W/B/R always flow so in-flight bursts finish.
  assign aw_adm       = !isolate_i && (wr_cnt_q < TxnW'(MaxTxns));
  assign ar_adm       = !isolate_i && (rd_cnt_q < TxnW'(MaxTxns));
  assign aw_in_valid  = slv_req_i.aw_valid && aw_adm;
  assign ar_in_valid  = slv_req_i.ar_valid && ar_adm;
  assign aw_slv_ready = aw_in_ready && aw_adm;
  assign ar_slv_ready = ar_in_ready && ar_adm;

  if (AwDepth == 0) begin : g_aw_bypass
    assign aw_in_ready = mst_resp_i.aw_ready;
    assign aw_out_valid = aw_in_valid;
    assign aw_out = slv_req_i.aw;
    assign aw_empty = 1'b1;
  end else begin : g_aw_fifo
    axi_chan_buffer_fifo #(.Depth(AwDepth), .data_t(aw_chan_t)) i_fifo (
      .clk_i, .rst_ni, .valid_i(aw_in_valid), .ready_o(aw_in_ready), .data_i(slv_req_i.aw),
      .valid_o(aw_out_valid), .ready_i(mst_resp_i.aw_ready), .data_o(aw_out));
    assign aw_empty = !aw_out_valid;
  end

  if (WDepth == 0) begin : g_w_bypass
    assign w_in_ready = mst_resp_i.w_ready;
    assign w_out_valid = slv_req_i.w_valid;
    assign w_out = slv_req_i.w;
    assign w_empty = 1'b1;
  end else begin : g_w_fifo
    axi_chan_buffer_fifo #(.Depth(WDepth), .data_t(w_chan_t)) i_fifo (
      .clk_i, .rst_ni, .valid_i(slv_req_i.w_valid), .ready_o(w_in_ready), .data_i(slv_req_i.w),
      .valid_o(w_out_valid), .ready_i(mst_resp_i.w_ready), .data_o(w_out));
    assign w_empty = !w_out_valid;
  end

  if (BDepth == 0) begin : g_b_bypass
    assign b_in_ready = slv_req_i.b_ready;
    assign b_out_valid = mst_resp_i.b_valid;
    assign b_out = mst_resp_i.b;
    assign b_empty = 1'b1;
  end else begin : g_b_fifo
    axi_chan_buffer_fifo #(.Depth(BDepth), .data_t(b_chan_t)) i_fifo (
      .clk_i, .rst_ni, .valid_i(mst_resp_i.b_valid), .ready_o(b_in_ready), .data_i(mst_resp_i.b),
      .valid_o(b_out_valid), .ready_i(slv_req_i.b_ready), .data_o(b_out));
    assign b_empty = !b_out_valid;
  end

  if (ArDepth == 0) begin : g_ar_bypass
    assign ar_in_ready = mst_resp_i.ar_ready;
    assign ar_out_valid = ar_in_valid;
    assign ar_out = slv_req_i.ar;
    assign ar_empty = 1'b1;
  end else begin : g_ar_fifo
    axi_chan_buffer_fifo #(.Depth(ArDepth), .data_t(ar_chan_t)) i_fifo (
      .clk_i, .rst_ni, .valid_i(ar_in_valid), .ready_o(ar_in_ready), .data_i(slv_req_i.ar),
      .valid_o(ar_out_valid), .ready_i(mst_resp_i.ar_ready), .data_o(ar_out));
    assign ar_empty = !ar_out_valid;
  end

  if (RDepth == 0) begin : g_r_bypass
    assign r_in_ready = slv_req_i.r_ready;
    assign r_out_valid = mst_resp_i.r_valid;
    assign r_out = mst_resp_i.r;
    assign r_empty = 1'b1;
  end else begin : g_r_fifo
    axi_chan_buffer_fifo #(.Depth(RDepth), .data_t(r_chan_t)) i_fifo (
      .clk_i, .rst_ni, .valid_i(mst_resp_i.r_valid), .ready_o(r_in_ready), .data_i(mst_resp_i.r),
      .valid_o(r_out_valid), .ready_i(slv_req_i.r_ready), .data_o(r_out));
    assign r_empty = !r_out_valid;
  end

  always_comb begin
    slv_resp_o          = '0;
    mst_req_o           = '0;
    mst_req_o.aw        = aw_out;
    mst_req_o.aw_valid  = aw_out_valid;
    mst_req_o.w         = w_out;
    mst_req_o.w_valid   = w_out_valid;
    mst_req_o.b_ready   = b_in_ready;
    mst_req_o.ar        = ar_out;
    mst_req_o.ar_valid  = ar_out_valid;
    mst_req_o.r_ready   = r_in_ready;
    slv_resp_o.aw_ready = aw_slv_ready;
    slv_resp_o.w_ready  = w_in_ready;
    slv_resp_o.b        = b_out;
    slv_resp_o.b_valid  = b_out_valid;
    slv_resp_o.ar_ready = ar_slv_ready;
    slv_resp_o.r        = r_out;
    slv_resp_o.r_valid  = r_out_valid;
  end

  assign aw_hs     = slv_req_i.aw_valid && aw_slv_ready;
  assign ar_hs     = slv_req_i.ar_valid && ar_slv_ready;
  assign b_hs      = b_out_valid && slv_req_i.b_ready;
  assign r_last_hs = r_out_valid && slv_req_i.r_ready && r_out.last;

  // A response with nothing outstanding is a protocol error; the counter stays at 0.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (aw_hs && !b_hs) wr_cnt_d = wr_cnt_q + 1'b1;
    else if (b_hs && !aw_hs && wr_cnt_q != '0) wr_cnt_d = wr_cnt_q - 1'b1;
    if (ar_hs && !r_last_hs) rd_cnt_d = rd_cnt_q + 1'b1;
    else if (r_last_hs && !ar_hs && rd_cnt_q != '0) rd_cnt_d = rd_cnt_q - 1'b1;
    isolated_d = isolate_i && (wr_cnt_q == '0) && (rd_cnt_q == '0) &&
                 aw_empty && w_empty && b_empty && ar_empty && r_empty;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      isolated_q <= 1'b0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      isolated_q <= isolated_d;
    end
  end

  assign isolated_o = isolated_q;

  assert property (@(posedge clk_i) disable iff (!rst_ni) !(b_hs && !aw_hs && wr_cnt_q == '0));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(r_last_hs && !ar_hs && rd_cnt_q == '0));

`ifdef AXI_CHAN_BUFFER_STALL_CNT_EN
  logic        stall;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall = (slv_req_i.aw_valid && !aw_slv_ready) || (slv_req_i.ar_valid && !ar_slv_ready);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_axi_chan_buffer.sv
// tb_axi_chan_buffer: scoreboard bench for axi_chan_buffer with AW bypassed, a 4-deep W FIFO
// and at most two outstanding transactions per direction.
module tb_axi_chan_buffer;
  typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; } aw_chan_t;
  typedef struct packed { logic [31:0] data; logic last; } w_chan_t;
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_chan_t;
  typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; } ar_chan_t;
  typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_chan_t;
  typedef struct packed {
    aw_chan_t aw; logic aw_valid; w_chan_t w; logic w_valid; logic b_ready;
    ar_chan_t ar; logic ar_valid; logic r_ready; } axi_req_t;
  typedef struct packed {
    logic aw_ready; logic ar_ready; logic w_ready; b_chan_t b; logic b_valid;
    r_chan_t r; logic r_valid; } axi_resp_t;

`ifdef AXI_CHAN_BUFFER_STALL_CNT_EN
  localparam logic [31:0] StallExp = 32'd10;
`else
  localparam logic [31:0] StallExp = 32'd0;
`endif

  logic        clk, rst_n, isolate, isolated;
  logic [31:0] stall_cnt;
  int          total, bad, w_seen;

  aw_chan_t exp_aw_q[$];
  w_chan_t  exp_w_q[$];
  b_chan_t  exp_b_q[$];
  ar_chan_t exp_ar_q[$];
  r_chan_t  exp_r_q[$];

  axi_chan_buffer_if #(.req_t(axi_req_t), .resp_t(axi_resp_t)) slv_if ();
  axi_chan_buffer_if #(.req_t(axi_req_t), .resp_t(axi_resp_t)) mst_if ();

  axi_chan_buffer #(
    .AwDepth(0), .WDepth(4), .BDepth(2), .ArDepth(2), .RDepth(2), .MaxTxns(2),
    .aw_chan_t(aw_chan_t), .w_chan_t(w_chan_t), .b_chan_t(b_chan_t),
    .ar_chan_t(ar_chan_t), .r_chan_t(r_chan_t),
    .axi_req_t(axi_req_t), .axi_resp_t(axi_resp_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_req_i(slv_if.req), .slv_resp_o(slv_if.resp),
    .mst_req_o(mst_if.req), .mst_resp_i(mst_if.resp),
    .isolate_i(isolate), .isolated_o(isolated), .stall_cnt_o(stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic aw_chan_t mk_aw(input logic [3:0] i_id, input logic [31:0] i_addr);
    mk_aw = '{id: i_id, addr: i_addr, len: 8'd0};
  endfunction

  function automatic ar_chan_t mk_ar(input logic [3:0] i_id, input logic [31:0] i_addr);
    mk_ar = '{id: i_id, addr: i_addr, len: 8'd0};
  endfunction

  // driver tasks: master-side responses
  task automatic send_b(input logic [3:0] id);
    mst_if.resp.b_valid = 1'b1;
    mst_if.resp.b = '{id: id, resp: 2'b00};
    for (int n = 0; n < 10 && !mst_if.req.b_ready; n++) tick();
    chk("b_push_ready", mst_if.req.b_ready, 1'b1);
    if (mst_if.req.b_ready) exp_b_q.push_back(mst_if.resp.b);
    tick();
    mst_if.resp.b_valid = 1'b0;
  endtask

  task automatic send_r(input logic [3:0] id, input logic [31:0] data, input logic last);
    mst_if.resp.r_valid = 1'b1;
    mst_if.resp.r = '{id: id, data: data, resp: 2'b00, last: last};
    for (int n = 0; n < 10 && !mst_if.req.r_ready; n++) tick();
    chk("r_push_ready", mst_if.req.r_ready, 1'b1);
    if (mst_if.req.r_ready) exp_r_q.push_back(mst_if.resp.r);
    tick();
    mst_if.resp.r_valid = 1'b0;
  endtask

  // scoreboard monitor: handshakes are evaluated half a cycle before the edge that takes them
  always @(negedge clk) begin
    if (rst_n) begin
      if (mst_if.req.aw_valid && mst_if.resp.aw_ready) begin
        chk("aw_queue_nonempty", exp_aw_q.size() != 0, 1'b1);
        if (exp_aw_q.size() != 0) chk("aw_beat", mst_if.req.aw, exp_aw_q.pop_front());
      end
      if (mst_if.req.w_valid && mst_if.resp.w_ready) begin
        w_seen++;
        chk("w_queue_nonempty", exp_w_q.size() != 0, 1'b1);
        if (exp_w_q.size() != 0) chk("w_beat", mst_if.req.w, exp_w_q.pop_front());
      end
      if (mst_if.req.ar_valid && mst_if.resp.ar_ready) begin
        chk("ar_queue_nonempty", exp_ar_q.size() != 0, 1'b1);
        if (exp_ar_q.size() != 0) chk("ar_beat", mst_if.req.ar, exp_ar_q.pop_front());
      end
      if (slv_if.resp.b_valid && slv_if.req.b_ready) begin
        chk("b_queue_nonempty", exp_b_q.size() != 0, 1'b1);
        if (exp_b_q.size() != 0) chk("b_beat", slv_if.resp.b, exp_b_q.pop_front());
      end
      if (slv_if.resp.r_valid && slv_if.req.r_ready) begin
        chk("r_queue_nonempty", exp_r_q.size() != 0, 1'b1);
        if (exp_r_q.size() != 0) chk("r_beat", slv_if.resp.r, exp_r_q.pop_front());
      end
    end
  end

  initial begin
    total = 0; bad = 0; w_seen = 0;
    rst_n = 1'b0; isolate = 1'b0;
    slv_if.req = '0;
    mst_if.resp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_slv_resp", slv_if.resp, '0);
    chk("rst_mst_req", mst_if.req, '0);
    chk("rst_isolated", isolated, 1'b0);
    chk("rst_stall", stall_cnt, 32'd0);
    rst_n = 1'b1;
    slv_if.req.b_ready = 1'b1;
    slv_if.req.r_ready = 1'b1;
    mst_if.resp.w_ready = 1'b1;
    mst_if.resp.ar_ready = 1'b1;
    mst_if.resp.aw_ready = 1'b1;
    repeat (2) tick();

    // isolation with nothing outstanding, AW held against it for 10 cycles
    isolate = 1'b1;
    slv_if.req.aw = mk_aw(4'd1, 32'h1000);
    slv_if.req.aw_valid = 1'b1;
    #1;
    chk("iso_aw_blocked", slv_if.resp.aw_ready, 1'b0);
    chk("iso_mst_aw_valid", mst_if.req.aw_valid, 1'b0);
    repeat (10) tick();
    chk("stall_cnt_10", stall_cnt, StallExp);
    chk("iso_idle_set", isolated, 1'b1);
    slv_if.req.aw_valid = 1'b0;
    isolate = 1'b0;
    #1;
    chk("iso_idle_hold", isolated, 1'b1);
    tick();
    chk("iso_idle_clear", isolated, 1'b0);

    // 16 back-to-back W beats with the master always ready
    w_seen = 0;
    for (int i = 0; i < 16; i++) begin
      slv_if.req.w_valid = 1'b1;
      slv_if.req.w = '{data: 32'h100 + 32'(i), last: (i == 15)};
      if (i == 0) chk("w_lat_before", mst_if.req.w_valid, 1'b0);
      if (i == 1) chk("w_lat_after", mst_if.req.w_valid, 1'b1);
      chk("w_stream_ready", slv_if.resp.w_ready, 1'b1);
      if (slv_if.resp.w_ready) exp_w_q.push_back(slv_if.req.w);
      tick();
    end
    slv_if.req.w_valid = 1'b0;
    tick();
    chk("w_stream_beats_17cyc", w_seen, 16);

    // fill the 4-deep W FIFO against a stalled master, fifth beat must wait
    mst_if.resp.w_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      slv_if.req.w_valid = 1'b1;
      slv_if.req.w = '{data: 32'h200 + 32'(i), last: 1'b1};
      #1;
      chk("w_fill_ready", slv_if.resp.w_ready, (i < 4));
      if (slv_if.resp.w_ready) begin
        exp_w_q.push_back(slv_if.req.w);
        tick();
      end
    end
    repeat (2) tick();
    chk("w_full_hold_ready", slv_if.resp.w_ready, 1'b0);
    chk("w_full_mst_valid", mst_if.req.w_valid, 1'b1);
    chk("w_full_head", mst_if.req.w.data, 32'h200);
    mst_if.resp.w_ready = 1'b1;
    for (int n = 0; n < 4 && !slv_if.resp.w_ready; n++) tick();
    chk("w_fill_resume", slv_if.resp.w_ready, 1'b1);
    if (slv_if.resp.w_ready) exp_w_q.push_back(slv_if.req.w);
    tick();
    slv_if.req.w_valid = 1'b0;
    for (int n = 0; n < 20 && exp_w_q.size() != 0; n++) tick();
    chk("w_fill_drain", exp_w_q.size(), 0);

    // AW bypass: combinational in both directions
    mst_if.resp.aw_ready = 1'b0;
    slv_if.req.aw = mk_aw(4'd2, 32'h2000);
    slv_if.req.aw_valid = 1'b1;
    #1;
    chk("aw_byp_valid", mst_if.req.aw_valid, 1'b1);
    chk("aw_byp_data", mst_if.req.aw, mk_aw(4'd2, 32'h2000));
    chk("aw_byp_ready_lo", slv_if.resp.aw_ready, 1'b0);
    mst_if.resp.aw_ready = 1'b1;
    #1;
    chk("aw_byp_ready_hi", slv_if.resp.aw_ready, 1'b1);
    exp_aw_q.push_back(mk_aw(4'd2, 32'h2000));
    tick();
    slv_if.req.aw = mk_aw(4'd3, 32'h3000);
    #1;
    chk("aw_second_ready", slv_if.resp.aw_ready, 1'b1);
    exp_aw_q.push_back(mk_aw(4'd3, 32'h3000));
    tick();

    // third AW blocked at MaxTxns=2 until a B is returned
    slv_if.req.aw = mk_aw(4'd4, 32'h4000);
    #1;
    chk("aw_max_block", slv_if.resp.aw_ready, 1'b0);
    chk("aw_max_mst_valid", mst_if.req.aw_valid, 1'b0);
    tick();
    chk("aw_max_block2", slv_if.resp.aw_ready, 1'b0);
    send_b(4'd2);
    chk("aw_max_b_in_fifo", slv_if.resp.aw_ready, 1'b0);
    tick();
    chk("aw_max_release", slv_if.resp.aw_ready, 1'b1);
    if (slv_if.resp.aw_ready) exp_aw_q.push_back(mk_aw(4'd4, 32'h4000));
    tick();
    slv_if.req.aw_valid = 1'b0;
    send_b(4'd3);
    for (int n = 0; n < 10 && exp_b_q.size() != 0; n++) tick();
    chk("b_drain", exp_b_q.size(), 0);

    // one write and one read outstanding, then isolate and drain
    slv_if.req.ar = mk_ar(4'd5, 32'h5000);
    slv_if.req.ar_valid = 1'b1;
    #1;
    chk("ar_accept", slv_if.resp.ar_ready, 1'b1);
    exp_ar_q.push_back(mk_ar(4'd5, 32'h5000));
    tick();
    slv_if.req.ar_valid = 1'b0;
    for (int n = 0; n < 10 && exp_ar_q.size() != 0; n++) tick();
    chk("ar_drain", exp_ar_q.size(), 0);

    isolate = 1'b1;
    slv_if.req.ar = mk_ar(4'd6, 32'h6000);
    slv_if.req.ar_valid = 1'b1;
    #1;
    chk("iso_ar_blocked", slv_if.resp.ar_ready, 1'b0);
    tick();
    chk("iso_pending", isolated, 1'b0);
    send_b(4'd4);
    for (int n = 0; n < 10 && exp_b_q.size() != 0; n++) tick();
    chk("iso_b_drain", exp_b_q.size(), 0);
    chk("iso_read_pending", isolated, 1'b0);
    send_r(4'd5, 32'hAAAA, 1'b0);
    send_r(4'd5, 32'hBBBB, 1'b1);
    for (int n = 0; n < 10 && !(slv_if.resp.r_valid && slv_if.resp.r.last); n++) tick();
    chk("iso_rlast_seen", slv_if.resp.r_valid && slv_if.resp.r.last, 1'b1);
    chk("iso_before_rlast", isolated, 1'b0);
    tick();
    chk("iso_at_rlast", isolated, 1'b0);
    tick();
    chk("iso_after_rlast", isolated, 1'b1);
    chk("iso_ar_still_blocked", slv_if.resp.ar_ready, 1'b0);

    isolate = 1'b0;
    #1;
    chk("resume_ar_ready", slv_if.resp.ar_ready, 1'b1);
    chk("resume_iso_hold", isolated, 1'b1);
    exp_ar_q.push_back(mk_ar(4'd6, 32'h6000));
    tick();
    slv_if.req.ar_valid = 1'b0;
    chk("resume_iso_clear", isolated, 1'b0);
    send_r(4'd6, 32'hCCCC, 1'b1);
    for (int n = 0; n < 10 && (exp_r_q.size() != 0 || exp_ar_q.size() != 0); n++) tick();
    chk("r_drain", exp_r_q.size(), 0);

    // reset mid-transfer discards buffered W beats
    mst_if.resp.w_ready = 1'b0;
    slv_if.req.w_valid = 1'b1;
    slv_if.req.w = '{data: 32'hDEAD, last: 1'b1};
    repeat (2) tick();
    slv_if.req.w_valid = 1'b0;
    chk("prereset_w_valid", mst_if.req.w_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_w_valid", mst_if.req.w_valid, 1'b0);
    chk("midrst_w_ready", slv_if.resp.w_ready, 1'b0);
    chk("midrst_stall", stall_cnt, 32'd0);
    chk("midrst_isolated", isolated, 1'b0);
    tick();
    rst_n = 1'b1;
    mst_if.resp.w_ready = 1'b1;
    w_seen = 0;
    repeat (4) tick();
    chk("postrst_no_w", w_seen, 0);

    chk("end_aw_q", exp_aw_q.size(), 0);
    chk("end_w_q", exp_w_q.size(), 0);
    chk("end_b_q", exp_b_q.size(), 0);
    chk("end_ar_q", exp_ar_q.size(), 0);
    chk("end_r_q", exp_r_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
